frontend_port_arbiter: RTL and testbench
========================================

# frontend_port_arbiter

Multi-port front end that places N client request channels ahead of the single UORAM command/data interface. It arbitrates among ports and issues one ORAM command at a time, forwarding the granted port's store burst intact. In-order load data is routed back to the originating port through a tag FIFO. It supersedes the single-client front-end wrapper for designs with several requesters (e.g. I- and D-side) sharing one ORAM.

## Interface
- NumPorts, 4: client channels, ≥2
- ORAMU, 32: program address width
- ORAMB, 512: block size in bits
- FEDWidth, 64: beat width; BlockBeats = ORAMB/FEDWidth (integer, ≥2)
- DMWidth, 8: write-mask width (one bit per beat)
- BECMDWidth, 2: command width
- TagDepth, 4: maximum outstanding read-type commands (power of two)
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- CmdInValid / CmdInReady  in/out  NumPorts  per-port command handshake
- CmdIn  in  NumPorts*BECMDWidth  per-port command; port i at slice i
- ProgAddrIn  in  NumPorts*ORAMU  per-port address
- WMaskIn  in  NumPorts*DMWidth  per-port write mask
- DataInValid / DataInReady  in/out  NumPorts  per-port store-data handshake
- DataIn  in  NumPorts*FEDWidth  per-port store data
- ReturnDataValid / ReturnDataReady  out/in  NumPorts  per-port load-data handshake
- ReturnData  out  FEDWidth  load data, shared by all ports
- CmdOutValid / CmdOutReady  out/in  1  command to UORAM controller
- CmdOut, AddrOut, WMaskOut  out  BECMDWidth, ORAMU, DMWidth  latched command fields
- StoreDataValid / StoreDataReady, StoreData  out/in, out  1, FEDWidth  store burst to controller
- LoadDataValid / LoadDataReady, LoadData  in/out, in  1, FEDWidth  load burst from controller

## Operation
- Write-type = Write, Append: BlockBeats store beats, no load data. Read-type = Read, ReadRmv: no store beats, BlockBeats load beats. Encodings come from the shared command constants.
- FSM: ST_Idle, ST_Cmd, ST_Store.
- ST_Idle: eligible = CmdInValid[i], masked to write-type when tag count == TagDepth. Round-robin pick starting from the port after the last grant. Latch port id, command, address and mask; pulse CmdInReady[winner] for one cycle; go to ST_Cmd. No eligible port: stay.
- ST_Cmd: CmdOutValid=1 with latched fields. On CmdOutReady: read-type pushes the port id into the tag FIFO and returns to ST_Idle; write-type clears the beat counter and goes to ST_Store.
- ST_Store: pass-through of the locked port. StoreDataValid=DataInValid[p], StoreData=DataIn[p], DataInReady[p]=StoreDataReady; all other DataInReady=0. Count handshakes; on beat BlockBeats-1 return to ST_Idle.
- Return path runs independently of the FSM. Head tag h selects the port: ReturnDataValid[h]=LoadDataValid, LoadDataReady=ReturnDataReady[h], ReturnData=LoadData. The load beat counter pops the FIFO on beat BlockBeats-1.
- Empty FIFO: LoadDataReady=0 and all ReturnDataValid=0. A LoadDataValid with no outstanding tag is a protocol error; it stalls and is not dropped.
- Push and pop in the same cycle: count unchanged. Push when full cannot occur because of the eligibility mask.

## Timing
- Reset values: all Ready/Valid outputs 0; CmdOut, AddrOut, WMaskOut, StoreData, ReturnData 0; FSM ST_Idle; RR pointer at port 0; FIFO empty; counters 0.
- Command latency: CmdInValid sampled in ST_Idle gives CmdOutValid on the next cycle; minimum 2 cycles per command (Idle→Cmd→Idle).
- Store and load paths: zero-latency combinational passthrough.
- CmdOutValid holds, with fields stable, until CmdOutReady.
- Reset asserted mid-burst aborts the burst immediately; partial store or load beats are discarded, with no recovery.

## Configuration
- FRONTEND_ARB_PRIO0_EN defined: port 0, when eligible, always wins; ports 1..N-1 round-robin among themselves.
- Undefined: pure round-robin over all ports.

## Structure
- Shared package holds command encodings, an is-read-type/is-write-type function, the FSM state enum, and a log2 helper.
- One sub-module, frontend_tag_fifo: a TagDepth × log2(NumPorts) FIFO with count, full and empty outputs.

## Test plan
- Single port 2 Read to 0x40, controller returns 8 beats 0..7 → exactly ports 2 beats 0..7 asserted on ReturnDataValid[2], tag FIFO empty afterwards.
- Ports 0..3 all valid Write at once, RR enabled → CmdOut order 0,1,2,3; each port's 8 store beats contiguous; no interleave even with StoreDataReady toggled every cycle.
- 5 back-to-back Reads with TagDepth=4 and LoadDataValid held low → 4 CmdOut handshakes, 5th stalled with CmdInReady=0; first load burst completing → 5th issues.
- Port 1 Read then port 3 Read, loads returned in order → beats 0..7 to port 1, then 8..15 to port 3; ReturnDataReady[1]=0 stalls LoadDataReady.
- FRONTEND_ARB_PRIO0_EN with ports 0 and 2 continuously valid → port 0 wins every arbitration; without macro → alternates 0,2,0,2.
- Reset asserted during beat 3 of a Write → all outputs 0 next edge; after release a new Read issues normally.

Source files
------------

// File: rtl/frontend_port_arbiter_pkg.sv
// Shared definitions for the multi-port ORAM front end: backend command
// encodings, command-class helpers, arbiter FSM states and a log2 helper.
package frontend_port_arbiter_pkg;

   localparam int BECMD_W = 2;

   localparam logic [BECMD_W-1:0] BECMD_Update  = 2'd0;
   localparam logic [BECMD_W-1:0] BECMD_Append  = 2'd1;
   localparam logic [BECMD_W-1:0] BECMD_Read    = 2'd2;
   localparam logic [BECMD_W-1:0] BECMD_ReadRmv = 2'd3;

   typedef enum logic [1:0] {
      ST_Idle  = 2'd0,
      ST_Cmd   = 2'd1,
      ST_Store = 2'd2
   } fe_state_t;

   // Read-type commands return a block of load beats.
   function automatic logic is_read_type(input logic [BECMD_W-1:0] cmd);
      return (cmd == BECMD_Read) || (cmd == BECMD_ReadRmv);
   endfunction

   // Write-type commands carry a block of store beats.
   function automatic logic is_write_type(input logic [BECMD_W-1:0] cmd);
      return (cmd == BECMD_Update) || (cmd == BECMD_Append);
   endfunction

   // Ceiling log2, never less than 1 so it can size any index vector.
   function automatic int log2c(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/frontend_tag_fifo.sv
// Tag FIFO holding the originating port of each outstanding read-type
// command, in issue order. Depth must be a power of two so the pointers
// wrap naturally.
module frontend_tag_fifo
   import frontend_port_arbiter_pkg::*;
#(
   parameter int Depth = 4,
   parameter int Width = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  push,
   input  logic [Width-1:0]      push_tag,
   input  logic                  pop,
   output logic [Width-1:0]      head,
   output logic [log2c(Depth):0] count,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = log2c(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(Depth));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Tag storage; contents are don't-care until written.
   always_ff @(posedge Clock) begin
      if (do_push) mem[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/frontend_port_arbiter.sv
// Multi-port front end ahead of a single UORAM command/data interface.
// One command is issued at a time; store bursts pass through from the
// granted port, load bursts are routed back using an in-order tag FIFO.
// Optional build macro FRONTEND_ARB_PRIO0_EN: port 0 wins whenever it is
// eligible, remaining ports share round-robin. Default is plain round-robin.
// Reset is asynchronous, active-low.
//
// state    | meaning
// ST_Idle  | arbitrate; grant and latch the winning port's command
// ST_Cmd   | present latched command until the controller accepts it
// ST_Store | pass the locked port's store burst through to the controller
module frontend_port_arbiter
   import frontend_port_arbiter_pkg::*;
#(
   parameter int NumPorts   = 4,
   parameter int ORAMU      = 32,
   parameter int ORAMB      = 512,
   parameter int FEDWidth   = 64,
   parameter int DMWidth    = 8,
   parameter int BECMDWidth = 2,
   parameter int TagDepth   = 4
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic [NumPorts-1:0]            CmdInValid,
   output logic [NumPorts-1:0]            CmdInReady,
   input  logic [NumPorts*BECMDWidth-1:0] CmdIn,
   input  logic [NumPorts*ORAMU-1:0]      ProgAddrIn,
   input  logic [NumPorts*DMWidth-1:0]    WMaskIn,
   input  logic [NumPorts-1:0]            DataInValid,
   output logic [NumPorts-1:0]            DataInReady,
   input  logic [NumPorts*FEDWidth-1:0]   DataIn,
   output logic [NumPorts-1:0]            ReturnDataValid,
   input  logic [NumPorts-1:0]            ReturnDataReady,
   output logic [FEDWidth-1:0]            ReturnData,
   output logic                           CmdOutValid,
   input  logic                           CmdOutReady,
   output logic [BECMDWidth-1:0]          CmdOut,
   output logic [ORAMU-1:0]               AddrOut,
   output logic [DMWidth-1:0]             WMaskOut,
   output logic                           StoreDataValid,
   input  logic                           StoreDataReady,
   output logic [FEDWidth-1:0]            StoreData,
   input  logic                           LoadDataValid,
   output logic                           LoadDataReady,
   input  logic [FEDWidth-1:0]            LoadData
);

   localparam int BlockBeats = ORAMB / FEDWidth;
   localparam int PortW      = log2c(NumPorts);
   localparam int BeatW      = log2c(BlockBeats);
   localparam int TagCntW    = log2c(TagDepth) + 1;

   fe_state_t            state;
   logic [PortW-1:0]     rr_ptr;
   logic [PortW-1:0]     port_q;
   logic [PortW-1:0]     winner;
   logic [PortW:0]       cand;
   logic                 found;
   logic [NumPorts-1:0]  elig;
   logic [BeatW-1:0]     store_cnt;
   logic [BeatW-1:0]     load_cnt;
   logic [PortW-1:0]     head_tag;
   logic [TagCntW-1:0]   tag_count;
   logic                 tag_full;
   logic                 tag_empty;
   logic                 tag_push;
   logic                 tag_pop;
   logic                 tags_exhausted;
   logic                 store_fire;
   logic                 load_fire;

   assign tags_exhausted = (tag_count == TagCntW'(TagDepth));

   // Eligible ports: any valid write-type, read-type only while tags remain.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NumPorts; i++) begin
         elig[i] = CmdInValid[i] &&
                   (!tags_exhausted || is_write_type(CmdIn[i*BECMDWidth +: BECMDWidth]));
      end
   end

   // Rotating search starting at rr_ptr (port 0 pre-empts when priority mode is built in).
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
`ifdef FRONTEND_ARB_PRIO0_EN
      if (elig[0]) begin
         winner = '0;
         found  = 1'b1;
      end
`endif
      for (int k = 0; k < NumPorts; k++) begin
         cand = {1'b0, rr_ptr} + (PortW+1)'(k);
         if (cand >= (PortW+1)'(NumPorts)) cand = cand - (PortW+1)'(NumPorts);
`ifdef FRONTEND_ARB_PRIO0_EN
         if (!found && (cand != '0) && elig[cand[PortW-1:0]]) begin
`else
         if (!found && elig[cand[PortW-1:0]]) begin
`endif
            winner = cand[PortW-1:0];
            found  = 1'b1;
         end
      end
   end

   // Command FSM: grant, issue, then carry the store burst for write-types.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= ST_Idle;
         rr_ptr    <= '0;
         port_q    <= '0;
         CmdOut    <= '0;
         AddrOut   <= '0;
         WMaskOut  <= '0;
         store_cnt <= '0;
      end else begin
         case (state)
            ST_Idle: begin
               if (found) begin
                  port_q   <= winner;
                  CmdOut   <= CmdIn[int'(winner)*BECMDWidth +: BECMDWidth];
                  AddrOut  <= ProgAddrIn[int'(winner)*ORAMU +: ORAMU];
                  WMaskOut <= WMaskIn[int'(winner)*DMWidth +: DMWidth];
                  rr_ptr   <= (winner == PortW'(NumPorts-1)) ? '0 : winner + 1'b1;
                  state    <= ST_Cmd;
               end
            end
            ST_Cmd: begin
               if (CmdOutReady) begin
                  if (is_read_type(CmdOut)) begin
                     state <= ST_Idle;
                  end else begin
                     store_cnt <= '0;
                     state     <= ST_Store;
                  end
               end
            end
            ST_Store: begin
               if (store_fire) begin
                  if (store_cnt == BeatW'(BlockBeats-1)) begin
                     store_cnt <= '0;
                     state     <= ST_Idle;
                  end else begin
                     store_cnt <= store_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_Idle;
         endcase
      end
   end

   // Command-side handshakes and store passthrough from the locked port.
   always_comb begin
      CmdInReady     = '0;
      DataInReady    = '0;
      StoreDataValid = 1'b0;
      StoreData      = '0;
      if (state == ST_Idle && found) CmdInReady[winner] = 1'b1;
      if (state == ST_Store) begin
         StoreDataValid      = DataInValid[port_q];
         StoreData           = DataIn[int'(port_q)*FEDWidth +: FEDWidth];
         DataInReady[port_q] = StoreDataReady;
      end
   end

   assign CmdOutValid = (state == ST_Cmd);
   assign store_fire  = StoreDataValid && StoreDataReady;
   assign tag_push    = CmdOutValid && CmdOutReady && is_read_type(CmdOut) && !tag_full;

   // Load return routing to the head tag; stalls when nothing is outstanding.
   always_comb begin
      ReturnDataValid = '0;
      LoadDataReady   = 1'b0;
      ReturnData      = '0;
      if (!tag_empty) begin
         ReturnDataValid[head_tag] = LoadDataValid;
         LoadDataReady             = ReturnDataReady[head_tag];
         ReturnData                = LoadData;
      end
   end

   assign load_fire = LoadDataValid && LoadDataReady;
   assign tag_pop   = load_fire && (load_cnt == BeatW'(BlockBeats-1));

   // Load beat counter; the last beat of a block retires its tag.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         load_cnt <= '0;
      end else if (load_fire) begin
         load_cnt <= tag_pop ? '0 : load_cnt + 1'b1;
      end
   end

   frontend_tag_fifo #(
      .Depth (TagDepth),
      .Width (PortW)
   ) u_tag_fifo (
      .Clock    (Clock),
      .Reset    (Reset),
      .push     (tag_push),
      .push_tag (port_q),
      .pop      (tag_pop),
      .head     (head_tag),
      .count    (tag_count),
      .full     (tag_full),
      .empty    (tag_empty)
   );

endmodule

// File: tb/tb_frontend_port_arbiter.sv
// Bench for frontend_port_arbiter: directed scenarios plus a randomized
// phase, each cycle checked against a transaction-level model of ports,
// tag queue and controller.
module tb_frontend_port_arbiter;

   localparam int NP   = 4;
   localparam int BB   = 8;
   localparam int TAGD = 4;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [7:0]  mask;
   } req_t;

   logic            clk;
   logic            rst_n;
   logic [NP-1:0]   CmdInValid, CmdInReady;
   logic [NP*2-1:0] CmdIn;
   logic [NP*32-1:0] ProgAddrIn;
   logic [NP*8-1:0] WMaskIn;
   logic [NP-1:0]   DataInValid, DataInReady;
   logic [NP*64-1:0] DataIn;
   logic [NP-1:0]   ReturnDataValid, ReturnDataReady;
   logic [63:0]     ReturnData;
   logic            CmdOutValid, CmdOutReady;
   logic [1:0]      CmdOut;
   logic [31:0]     AddrOut;
   logic [7:0]      WMaskOut;
   logic            StoreDataValid, StoreDataReady;
   logic [63:0]     StoreData;
   logic            LoadDataValid, LoadDataReady;
   logic [63:0]     LoadData;

   frontend_port_arbiter dut (
      .Clock(clk), .Reset(rst_n),
      .CmdInValid(CmdInValid), .CmdInReady(CmdInReady), .CmdIn(CmdIn),
      .ProgAddrIn(ProgAddrIn), .WMaskIn(WMaskIn),
      .DataInValid(DataInValid), .DataInReady(DataInReady), .DataIn(DataIn),
      .ReturnDataValid(ReturnDataValid), .ReturnDataReady(ReturnDataReady),
      .ReturnData(ReturnData),
      .CmdOutValid(CmdOutValid), .CmdOutReady(CmdOutReady), .CmdOut(CmdOut),
      .AddrOut(AddrOut), .WMaskOut(WMaskOut),
      .StoreDataValid(StoreDataValid), .StoreDataReady(StoreDataReady),
      .StoreData(StoreData),
      .LoadDataValid(LoadDataValid), .LoadDataReady(LoadDataReady),
      .LoadData(LoadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   // model state
   req_t        req_q [NP][$];
   logic [63:0] st_q  [NP][$];
   logic [63:0] rx_q  [NP][$];
   logic [63:0] ld_q  [$];
   int          outst [$];
   int          grants[$];
   int          m_ptr, ld_beat, st_port, st_left, pend_port, n_rd_out;
   logic [63:0] ld_seq;
   bit          cmd_pend;
   req_t        pend;
   bit          load_en, sdr_toggle;
   logic [NP-1:0] ret_block;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_rd(input logic [1:0] c);
      return (c == 2'd2) || (c == 2'd3);
   endfunction

   function automatic req_t mk_req(input logic [1:0] c);
      req_t r;
      r.cmd  = c;
      r.addr = $urandom;
      r.mask = 8'($urandom);
      return r;
   endfunction

   // Round-robin from the port after the last grant.
   function automatic int model_pick(input logic [NP-1:0] e);
      int p;
`ifdef FRONTEND_ARB_PRIO0_EN
      if (e[0]) return 0;
`endif
      for (int k = 0; k < NP; k++) begin
         p = (m_ptr + k) % NP;
`ifdef FRONTEND_ARB_PRIO0_EN
         if (p == 0) continue;
`endif
         if (e[p]) return p;
      end
      return -1;
   endfunction

   function automatic bit quiet();
      for (int p = 0; p < NP; p++)
         if (req_q[p].size() > 0 || st_q[p].size() > 0) return 1'b0;
      return (ld_q.size() == 0) && (outst.size() == 0) && !cmd_pend && (st_left == 0);
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         req_q[p].delete(); st_q[p].delete(); rx_q[p].delete();
      end
      ld_q.delete(); outst.delete(); grants.delete();
      m_ptr = 0; ld_beat = 0; st_left = 0; st_port = 0; cmd_pend = 1'b0;
      pend_port = 0; ret_block = '0;
   endtask

   task automatic clear_inputs();
      CmdInValid = '0; CmdIn = '0; ProgAddrIn = '0; WMaskIn = '0;
      DataInValid = '0; DataIn = '0; ReturnDataReady = '0;
      CmdOutReady = 1'b0; StoreDataReady = 1'b0; LoadDataValid = 1'b0; LoadData = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cmd_in_ready"}, CmdInReady, 0);
      chk({tag, "_data_in_ready"}, DataInReady, 0);
      chk({tag, "_ret_valid"}, ReturnDataValid, 0);
      chk({tag, "_cmd_out_valid"}, CmdOutValid, 0);
      chk({tag, "_store_valid"}, StoreDataValid, 0);
      chk({tag, "_load_ready"}, LoadDataReady, 0);
      chk({tag, "_cmd_out"}, CmdOut, 0);
      chk({tag, "_addr_out"}, AddrOut, 0);
      chk({tag, "_wmask_out"}, WMaskOut, 0);
      chk({tag, "_store_data"}, StoreData, 0);
      chk({tag, "_ret_data"}, ReturnData, 0);
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         if (req_q[p].size() > 0) begin
            CmdInValid[p]       = 1'b1;
            CmdIn[p*2 +: 2]     = req_q[p][0].cmd;
            ProgAddrIn[p*32 +: 32] = req_q[p][0].addr;
            WMaskIn[p*8 +: 8]   = req_q[p][0].mask;
         end else begin
            CmdInValid[p]       = 1'b0;
            CmdIn[p*2 +: 2]     = 2'($urandom);
            ProgAddrIn[p*32 +: 32] = $urandom;
            WMaskIn[p*8 +: 8]   = 8'($urandom);
         end
         if (st_q[p].size() > 0) begin
            DataInValid[p]      = ($urandom_range(0, 3) != 0);
            DataIn[p*64 +: 64]  = st_q[p][0];
         end else begin
            DataInValid[p]      = 1'b0;
            DataIn[p*64 +: 64]  = {$urandom, $urandom};
         end
         ReturnDataReady[p] = !ret_block[p] && ($urandom_range(0, 3) != 0);
      end
      CmdOutReady = 1'($urandom_range(0, 1));
      if (sdr_toggle) StoreDataReady = !StoreDataReady;
      else            StoreDataReady = ($urandom_range(0, 3) != 0);
      if (ld_q.size() > 0) begin
         LoadDataValid = load_en && ($urandom_range(0, 3) != 0);
         LoadData      = ld_q[0];
      end else begin
         LoadDataValid = 1'b0;
         LoadData      = {$urandom, $urandom};
      end
   endtask

   // One clock: drive at the falling edge, check/observe, advance model, wait for the rising edge.
   task automatic cycle();
      logic [NP-1:0] elig, exp_cir, exp_dir, exp_rv;
      logic          exp_sv, exp_ldr;
      int            w, h;
      @(negedge clk);
      drive();
      #1;
      for (int p = 0; p < NP; p++) begin
         elig[p] = 1'b0;
         if (req_q[p].size() > 0)
            elig[p] = (outst.size() < TAGD) || !is_rd(req_q[p][0].cmd);
      end
      w = -1;
      exp_cir = '0;
      if (!cmd_pend && st_left == 0) begin
         w = model_pick(elig);
         if (w >= 0) exp_cir[w] = 1'b1;
      end
      chk("cmd_in_ready", CmdInReady, exp_cir);
      chk("cmd_out_valid", CmdOutValid, cmd_pend);
      if (cmd_pend) begin
         chk("cmd_out", CmdOut, pend.cmd);
         chk("addr_out", AddrOut, pend.addr);
         chk("wmask_out", WMaskOut, pend.mask);
      end
      exp_dir = '0;
      exp_sv  = 1'b0;
      if (st_left > 0) begin
         exp_dir[st_port] = StoreDataReady;
         exp_sv           = DataInValid[st_port];
      end
      chk("data_in_ready", DataInReady, exp_dir);
      chk("store_valid", StoreDataValid, exp_sv);
      if (exp_sv) chk("store_data", StoreData, st_q[st_port][0]);
      exp_rv  = '0;
      exp_ldr = 1'b0;
      h = -1;
      if (outst.size() > 0) begin
         h = outst[0];
         exp_rv[h] = LoadDataValid;
         exp_ldr   = ReturnDataReady[h];
      end
      chk("ret_valid", ReturnDataValid, exp_rv);
      chk("load_ready", LoadDataReady, exp_ldr);
      chk("ret_data", ReturnData, (h >= 0) ? LoadData : 64'd0);

      for (int p = 0; p < NP; p++) begin
         if (CmdInReady[p] && CmdInValid[p]) grants.push_back(p);
         if (ReturnDataValid[p] && ReturnDataReady[p]) rx_q[p].push_back(ReturnData);
      end
      if (CmdOutValid && CmdOutReady && is_rd(CmdOut)) n_rd_out++;

      if (exp_sv && StoreDataReady) begin
         void'(st_q[st_port].pop_front());
         st_left--;
      end
      if (h >= 0 && LoadDataValid && exp_ldr) begin
         void'(ld_q.pop_front());
         ld_beat++;
         if (ld_beat == BB) begin
            ld_beat = 0;
            void'(outst.pop_front());
         end
      end
      if (w >= 0) begin
         pend      = req_q[w].pop_front();
         pend_port = w;
         cmd_pend  = 1'b1;
         m_ptr     = (w + 1) % NP;
      end else if (cmd_pend && CmdOutReady) begin
         cmd_pend = 1'b0;
         if (is_rd(pend.cmd)) begin
            outst.push_back(pend_port);
            for (int b = 0; b < BB; b++) begin
               ld_q.push_back(ld_seq);
               ld_seq++;
            end
         end else begin
            st_port = pend_port;
            st_left = BB;
            for (int b = 0; b < BB; b++) st_q[pend_port].push_back({$urandom, $urandom});
         end
      end
      @(posedge clk);
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (!quiet() && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, quiet(), 1'b1);
   endtask

   int base, p, prio_exp[6];

   initial begin
      n_cmp = 0; n_err = 0; n_rd_out = 0; ld_seq = 0;
      load_en = 1'b1; sdr_toggle = 1'b0;
      model_reset();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // all four ports write together, store ready toggling
      sdr_toggle = 1'b1;
      for (int i = 0; i < NP; i++) req_q[i].push_back(mk_req(2'($urandom_range(0, 1))));
      drain("t2_drain", 400);
      sdr_toggle = 1'b0;
      chk("t2_grant_count", grants.size(), 4);
      if (grants.size() == 4)
         for (int i = 0; i < 4; i++) chk("t2_grant_order", grants[i], i);

      // single read from port 2 with sequential load data
      ld_seq = 0;
      for (int i = 0; i < NP; i++) rx_q[i].delete();
      req_q[2].push_back(mk_req(2'd2));
      drain("t1_drain", 200);
      chk("t1_rx_count", rx_q[2].size(), 8);
      if (rx_q[2].size() == 8)
         for (int i = 0; i < 8; i++) chk("t1_rx_beat", rx_q[2][i], 64'(i));
      @(negedge clk);
      LoadDataValid = 1'b1; ReturnDataReady = '1;
      #1;
      chk("t1_empty_load_ready", LoadDataReady, 1'b0);
      chk("t1_empty_ret_valid", ReturnDataValid, 0);

      // port 1 read then port 3 read, port 1 return stalled for a while
      ld_seq = 0;
      for (int i = 0; i < NP; i++) rx_q[i].delete();
      load_en = 1'b0;
      req_q[1].push_back(mk_req(2'd3));
      for (int i = 0; i < 50 && outst.size() < 1; i++) cycle();
      req_q[3].push_back(mk_req(2'd2));
      for (int i = 0; i < 50 && outst.size() < 2; i++) cycle();
      chk("t4_outstanding", outst.size(), 2);
      ret_block[1] = 1'b1;
      load_en = 1'b1;
      repeat (10) cycle();
      chk("t4_stall_rx", rx_q[1].size(), 0);
      ret_block[1] = 1'b0;
      drain("t4_drain", 300);
      chk("t4_rx1_count", rx_q[1].size(), 8);
      chk("t4_rx3_count", rx_q[3].size(), 8);
      if (rx_q[1].size() == 8 && rx_q[3].size() == 8)
         for (int i = 0; i < 8; i++) begin
            chk("t4_rx1_beat", rx_q[1][i], 64'(i));
            chk("t4_rx3_beat", rx_q[3][i], 64'(i + 8));
         end

      // ports 0 and 2 continuously requesting
      grants.delete();
      for (int i = 0; i < 3; i++) begin
         req_q[0].push_back(mk_req(2'd0));
         req_q[2].push_back(mk_req(2'd1));
      end
      drain("t5_drain", 600);
`ifdef FRONTEND_ARB_PRIO0_EN
      prio_exp = '{0, 0, 0, 2, 2, 2};
`else
      prio_exp = '{0, 2, 0, 2, 0, 2};
`endif
      chk("t5_grant_count", grants.size(), 6);
      if (grants.size() == 6)
         for (int i = 0; i < 6; i++) chk("t5_grant_order", grants[i], prio_exp[i]);

      // five reads with loads held off: tag limit
      base = n_rd_out;
      load_en = 1'b0;
      for (int i = 0; i < 5; i++) req_q[1].push_back(mk_req(2'd2));
      repeat (60) cycle();
      chk("t3_issued_before_load", n_rd_out - base, 4);
      chk("t3_stalled_pending", req_q[1].size(), 1);
      load_en = 1'b1;
      for (int i = 0; i < 200 && (n_rd_out - base) < 5; i++) cycle();
      chk("t3_fifth_issued", n_rd_out - base, 5);
      drain("t3_drain", 800);

      // reset during beat 3 of a write burst
      req_q[0].push_back(mk_req(2'd0));
      for (int i = 0; i < 100 && st_left != 5; i++) cycle();
      chk("t6_reach_beat3", st_left, 5);
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      #1;
      chk_zero("t6_async");
      model_reset();
      @(posedge clk);
      #1;
      chk_zero("t6_edge");
      @(negedge clk);
      rst_n = 1'b1;
      ld_seq = 0;
      req_q[2].push_back(mk_req(2'd2));
      req_q[1].push_back(mk_req(2'd1));
      drain("t6_drain", 300);
      chk("t6_rx_count", rx_q[2].size(), 8);

      // randomized traffic on all ports
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            p = $urandom_range(0, NP - 1);
            if (req_q[p].size() < 3) req_q[p].push_back(mk_req(2'($urandom_range(0, 3))));
         end
         cycle();
      end
      drain("rand_drain", 3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
